// File: rtl/deserializer_aligner.sv
// Serial-to-parallel receiver that finds frame alignment on a periodic sync word and emits the frame's data words.
// Optional DESER_ALIGN_ERR_CNT_EN adds a saturating 16-bit sync-miss counter on err_cnt_o.
module deserializer_aligner #(
  parameter int unsigned          C_WIDTH      = 8,
  parameter logic [C_WIDTH-1:0]   C_SYNC_WORD  = C_WIDTH'(8'hA5),
  parameter int unsigned          C_FRAME_LEN  = 4,
  parameter int unsigned          C_LOCK_CNT   = 2,
  parameter int unsigned          C_UNLOCK_CNT = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               serial_i,
  input  logic               serial_valid_i,
  output logic [C_WIDTH-1:0] word_o,
  output logic               word_valid_o,
  output logic               sof_o,
`ifdef DESER_ALIGN_ERR_CNT_EN
  output logic [15:0]        err_cnt_o,
`endif
  output logic               locked_o
);

  localparam int unsigned BW = $clog2(C_WIDTH);
  localparam int unsigned WW = $clog2(C_FRAME_LEN);
  localparam int unsigned MW = $clog2(C_LOCK_CNT + 1);
  localparam int unsigned UW = $clog2(C_UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             r_state,      w_state_nxt;
  logic [C_WIDTH-2:0] r_shift,      w_shift_nxt;
  logic [BW-1:0]      r_bit_cnt,    w_bit_cnt_nxt;
  logic [WW-1:0]      r_word_cnt,   w_word_cnt_nxt;
  logic [MW-1:0]      r_match_cnt,  w_match_cnt_nxt;
  logic [UW-1:0]      r_miss_cnt,   w_miss_cnt_nxt;
  logic [C_WIDTH-1:0] r_word,       w_word_nxt;
  logic               r_word_valid, w_word_valid_nxt;
  logic               r_sof,        w_sof_nxt;
  logic               r_locked,     w_locked_nxt;

  // Window ending at the current bit; r_shift keeps only the bits that survive the next shift.
  logic [C_WIDTH-1:0] w_shift_in;
  logic               w_boundary;
  logic               w_sync_slot;
  logic               w_sync_match;

  assign w_shift_in   = {serial_i, r_shift};
  assign w_boundary   = serial_valid_i && (r_bit_cnt == BW'(C_WIDTH - 1));
  assign w_sync_slot  = w_boundary && (r_word_cnt == '0);
  assign w_sync_match = (w_shift_in == C_SYNC_WORD);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_word_cnt_nxt   = r_word_cnt;
    w_match_cnt_nxt  = r_match_cnt;
    w_miss_cnt_nxt   = r_miss_cnt;
    w_word_nxt       = r_word;
    w_word_valid_nxt = 1'b0;
    w_sof_nxt        = 1'b0;

    if (serial_valid_i) begin
      w_shift_nxt = w_shift_in[C_WIDTH-1:1];
      case (r_state)
        ST_HUNT: begin
          if (w_sync_match) begin
            w_bit_cnt_nxt   = '0;
            w_word_cnt_nxt  = WW'(1);
            w_match_cnt_nxt = MW'(1);
            w_state_nxt     = (C_LOCK_CNT == 32'd1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        default: begin
          if (w_boundary) begin
            w_bit_cnt_nxt  = '0;
            w_word_cnt_nxt = (r_word_cnt == WW'(C_FRAME_LEN - 1)) ? '0 : r_word_cnt + WW'(1);
          end else begin
            w_bit_cnt_nxt  = r_bit_cnt + BW'(1);
          end

          if (w_sync_slot) begin
            if (w_sync_match) begin
              if (r_state == ST_VERIFY) begin
                w_match_cnt_nxt = r_match_cnt + MW'(1);
                if (r_match_cnt + MW'(1) == MW'(C_LOCK_CNT)) begin
                  w_state_nxt = ST_LOCKED;
                end
              end else begin
                w_miss_cnt_nxt = '0;
              end
            end else if ((r_state == ST_VERIFY) ||
                         (r_miss_cnt + UW'(1) == UW'(C_UNLOCK_CNT))) begin
              // Lost alignment: restart the search from the next valid bit
              w_state_nxt     = ST_HUNT;
              w_bit_cnt_nxt   = '0;
              w_word_cnt_nxt  = '0;
              w_match_cnt_nxt = '0;
              w_miss_cnt_nxt  = '0;
            end else begin
              w_miss_cnt_nxt = r_miss_cnt + UW'(1);
            end
          end else if (w_boundary && (r_state == ST_LOCKED)) begin
            w_word_nxt       = w_shift_in;
            w_word_valid_nxt = 1'b1;
            w_sof_nxt        = (r_word_cnt == WW'(1));
          end
        end
      endcase
    end

    w_locked_nxt = (w_state_nxt == ST_LOCKED);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= ST_HUNT;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_word_cnt   <= '0;
      r_match_cnt  <= '0;
      r_miss_cnt   <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_sof        <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_word_cnt   <= w_word_cnt_nxt;
      r_match_cnt  <= w_match_cnt_nxt;
      r_miss_cnt   <= w_miss_cnt_nxt;
      r_word       <= w_word_nxt;
      r_word_valid <= w_word_valid_nxt;
      r_sof        <= w_sof_nxt;
      r_locked     <= w_locked_nxt;
    end
  end

`ifdef DESER_ALIGN_ERR_CNT_EN
  logic [15:0] r_err_cnt;
  logic        w_sync_miss;

  assign w_sync_miss = (r_state != ST_HUNT) && w_sync_slot && !w_sync_match;

  // Saturating sync-miss counter, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err_cnt <= '0;
    end else if (w_sync_miss && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`endif

  assign word_o       = r_word;
  assign word_valid_o = r_word_valid;
  assign sof_o        = r_sof;
  assign locked_o     = r_locked;

endmodule

// File: tb/tb_deserializer_aligner.sv
// Scoreboard bench for deserializer_aligner: directed bit streams, expected words queued, monitor compares on word_valid_o.
module tb_deserializer_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ser;
  logic        ser_vld;
  logic [7:0]  word;
  logic        wv;
  logic        sof;
  logic        locked;
`ifdef DESER_ALIGN_ERR_CNT_EN
  logic [15:0] err;
`endif

  deserializer_aligner dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .serial_i       (ser),
    .serial_valid_i (ser_vld),
    .word_o         (word),
    .word_valid_o   (wv),
    .sof_o          (sof),
`ifdef DESER_ALIGN_ERR_CNT_EN
    .err_cnt_o      (err),
`endif
    .locked_o       (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] w;
    logic       sof;
    int         gap;   // expected cycles since previous pulse, 0 = not checked
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   last_cyc = 0;
  int   stride   = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop one expected word per output pulse
  always @(negedge clk) begin
    if (wv === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word got %0h expected no pulse at cycle %0d", word, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("word", 32'(word), 32'(e.w));
        check("sof", 32'(sof), 32'(e.sof));
        if (e.gap != 0) check("gap", 32'(cyc - last_cyc), 32'(e.gap));
      end
      last_cyc = cyc;
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    ser     = b;
    ser_vld = 1'b1;
    if (stride == 2) begin
      @(negedge clk);
      ser_vld = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_frame(input logic [7:0] s, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
    send_byte(s);
    send_byte(d1);
    send_byte(d2);
    send_byte(d3);
  endtask

  task automatic push(input logic [7:0] w, input logic s, input int gap);
    exp_t e;
    e.w   = w;
    e.sof = s;
    e.gap = gap;
    q.push_back(e);
  endtask

  task automatic exp_frame(input logic [7:0] d1, input logic [7:0] d2,
                           input logic [7:0] d3, input bit first);
    push(d1, 1'b1, first ? 0 : 16 * stride);
    push(d2, 1'b0, 8 * stride);
    push(d3, 1'b0, 8 * stride);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ser_vld = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    ser_vld = 1'b0;
    @(negedge clk);
    check("rst_word_valid", 32'(wv), 32'd0);
    check("rst_sof", 32'(sof), 32'd0);
    check("rst_word", 32'(word), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
`ifdef DESER_ALIGN_ERR_CNT_EN
    check("rst_err_cnt", 32'(err), 32'd0);
`endif
    rst_n = 1'b1;
  endtask

  task automatic junk();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    ser     = 1'b0;
    ser_vld = 1'b0;

    // Lock from junk-prefixed stream, continuous valid
    stride = 1;
    do_reset();
    junk();
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);
    check("locked_in_verify", 32'(locked), 32'd0);
    exp_frame(8'h11, 8'h22, 8'h33, 1'b1);
    send_byte(8'hA5);
    send_byte(8'h11);
    check("locked_after_2nd_sync", 32'(locked), 32'd1);
    send_byte(8'h22);
    send_byte(8'h33);
    exp_frame(8'h11, 8'h22, 8'h33, 1'b0);
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);
    exp_frame(8'h11, 8'h22, 8'h33, 1'b0);
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);

    // Data word equal to the sync pattern is plain data
    push(8'h11, 1'b1, 16);
    push(8'hA5, 1'b0, 8);
    push(8'h33, 1'b0, 8);
    send_frame(8'hA5, 8'h11, 8'hA5, 8'h33);
    exp_frame(8'h11, 8'h22, 8'h33, 1'b0);
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);

    // Single corrupt sync tolerated, two in a row drop lock
    exp_frame(8'h11, 8'h22, 8'h33, 1'b0);
    send_frame(8'hA4, 8'h11, 8'h22, 8'h33);
    check("locked_after_one_miss", 32'(locked), 32'd1);
`ifdef DESER_ALIGN_ERR_CNT_EN
    check("err_cnt_one_miss", 32'(err), 32'd1);
`endif
    exp_frame(8'h11, 8'h22, 8'h33, 1'b0);
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);
    exp_frame(8'h11, 8'h22, 8'h33, 1'b0);
    send_frame(8'hA4, 8'h11, 8'h22, 8'h33);
    send_frame(8'hA4, 8'h11, 8'h22, 8'h33);
    check("unlocked_after_two_miss", 32'(locked), 32'd0);
`ifdef DESER_ALIGN_ERR_CNT_EN
    check("err_cnt_three_miss", 32'(err), 32'd3);
`endif
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);
    exp_frame(8'h11, 8'h22, 8'h33, 1'b1);
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);
    exp_frame(8'h11, 8'h22, 8'h33, 1'b0);
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);
    idle(20);

    // Same stream with valid low every other cycle
    stride = 2;
    do_reset();
    junk();
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);
    exp_frame(8'h11, 8'h22, 8'h33, 1'b1);
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);
    exp_frame(8'h11, 8'h22, 8'h33, 1'b0);
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);
    idle(40);

    // Bad second sync in VERIFY returns to HUNT, then relock
    stride = 1;
    do_reset();
    junk();
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);
    send_frame(8'h5A, 8'h11, 8'h22, 8'h33);
    check("locked_after_verify_fail", 32'(locked), 32'd0);
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);
    exp_frame(8'h11, 8'h22, 8'h33, 1'b1);
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);
    idle(20);

    // Reset in the middle of data word 22 while locked
    do_reset();
    junk();
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);
    exp_frame(8'h11, 8'h22, 8'h33, 1'b1);
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);
    push(8'h11, 1'b1, 16);
    send_byte(8'hA5);
    send_byte(8'h11);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    do_reset();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_byte(8'h33);
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);
    check("locked_after_reset_one_sync", 32'(locked), 32'd0);
    exp_frame(8'h11, 8'h22, 8'h33, 1'b1);
    send_frame(8'hA5, 8'h11, 8'h22, 8'h33);
    idle(20);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
